// File: rtl/iscas_bist_ctrl.sv
// BIST controller for combinational ISCAS-85 netlists: drives exhaustive or LFSR patterns,
// compacts the responses into a MISR signature and compares it with a golden value.
// Optional feature macro: ISCAS_BIST_LFSR_EN compiles in the LFSR pattern generator; without
// it the controller is exhaustive-only and lfsr_mode_i is ignored.
module iscas_bist_ctrl #(
  parameter int unsigned       N_IN      = 5,
  parameter int unsigned       N_OUT     = 2,
  parameter int unsigned       SETTLE    = 1,
  parameter int unsigned       MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
  parameter logic [N_IN-1:0]   LFSR_TAPS = 5'h14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              lfsr_mode_i,
  input  logic [MISR_W-1:0] golden_i,
  output logic [N_IN-1:0]   dut_in_o,
  input  logic [N_OUT-1:0]  dut_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [MISR_W-1:0] signature_o,
  output logic [N_IN:0]     pat_cnt_o
);

  localparam int unsigned     CntW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
  // Index of the final pattern: 2^N_IN-1 exhaustive, one fewer for the LFSR (no all-zero).
  localparam logic [N_IN:0]   LastExh    = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0]   LastLfsr   = LastExh - (N_IN + 1)'(1);

  typedef enum logic [1:0] {StIdle, StApply, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [N_IN-1:0]     pat_q, pat_d;
  logic [MISR_W-1:0]   sig_q, sig_d;
  logic [N_IN:0]       pat_cnt_q, pat_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic                lfsr_req;
  logic [N_IN-1:0]     pat_adv;
  logic [MISR_W-1:0]   misr_next;
  logic [N_IN:0]       last_idx;

`ifdef ISCAS_BIST_LFSR_EN
  assign lfsr_req = lfsr_mode_i;
`else
  logic unused_lfsr;
  assign lfsr_req    = 1'b0;
  assign unused_lfsr = ^{lfsr_mode_i, LFSR_TAPS};
`endif

  assign last_idx  = mode_q ? LastLfsr : LastExh;
  assign misr_next = {sig_q[MISR_W-2:0], 1'b0} ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                     ^ MISR_W'(dut_out_i);

  // Next pattern: binary count, or Galois right-shift LFSR step when selected.
  always_comb begin
    pat_adv = pat_q + N_IN'(1);
`ifdef ISCAS_BIST_LFSR_EN
    if (mode_q) begin
      pat_adv = (pat_q >> 1) ^ (pat_q[0] ? LFSR_TAPS : '0);
    end
`endif
  end

  // Run sequencing: accept start, hold each pattern SETTLE cycles, capture, finish.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    pat_d     = pat_q;
    sig_d     = sig_q;
    pat_cnt_d = pat_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d    = lfsr_req;
          sig_d     = '0;
          pat_cnt_d = '0;
          pass_d    = 1'b0;
          pat_d     = lfsr_req ? N_IN'(1) : '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StApply;
        end
      end
      StApply: begin
        if (cnt_q == SettleLast) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCapture: begin
        sig_d     = misr_next;
        pat_cnt_d = pat_cnt_q + (N_IN + 1)'(1);
        cnt_d     = '0;
        if (pat_cnt_q == last_idx) begin
          // Outputs of the DONE cycle are registered here so they appear together.
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pat_d   = '0;
          pass_d  = (misr_next == golden_i);
        end else begin
          pat_d   = pat_adv;
          state_d = StApply;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      pat_q     <= '0;
      sig_q     <= '0;
      pat_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      sig_q     <= sig_d;
      pat_cnt_q <= pat_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign dut_in_o    = pat_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign signature_o = sig_q;
  assign pat_cnt_o   = pat_cnt_q;

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// Self-checking bench for iscas_bist_ctrl driving a c17 model, an all-zero circuit and
// random truth tables; expectations come from a pattern-list/MISR reference model.
module tb_iscas_bist_ctrl;

`ifdef ISCAS_BIST_LFSR_EN
  localparam bit LfsrEn = 1'b1;
`else
  localparam bit LfsrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        lfsr_mode;
  logic [15:0] golden;
  logic [4:0]  dut_in;
  logic [1:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [5:0]  pat_cnt;

  int          ckt_sel = 0;
  logic [1:0]  rand_tt [32];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic [4:0]  exp_pats [$];

  typedef struct {
    bit          mode;
    int          ckt;
    logic [15:0] gxor;
    bit          spam;
  } vec_t;

  vec_t vecs [7];

  iscas_bist_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .lfsr_mode_i (lfsr_mode),
    .golden_i    (golden),
    .dut_in_o    (dut_in),
    .dut_out_i   (dut_out),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .signature_o (signature),
    .pat_cnt_o   (pat_cnt)
  );

  always #5 clk = ~clk;

  // c17: inputs {N1,N2,N3,N6,N7}, outputs {N22,N23}.
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = p;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic logic [1:0] resp(input int ckt, input logic [4:0] p);
    if (ckt == 0) return c17(p);
    if (ckt == 1) return 2'b00;
    return rand_tt[p];
  endfunction

  assign dut_out = (ckt_sel == 0) ? c17(dut_in) : (ckt_sel == 1) ? 2'b00 : rand_tt[dut_in];

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list of applied patterns and the MISR over their responses.
  task automatic build_model(input bit lfsr, input int ckt, output logic [15:0] sig);
    int         n;
    logic [4:0] p;
    exp_pats.delete();
    sig = 16'h0;
    n = lfsr ? 31 : 32;
    p = lfsr ? 5'd1 : 5'd0;
    for (int i = 0; i < n; i++) begin
      if (!lfsr) p = i[4:0];
      exp_pats.push_back(p);
      sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {14'b0, resp(ckt, p)};
      if (lfsr) p = (p >> 1) ^ (p[0] ? 5'h14 : 5'h00);
    end
  endtask

  task automatic run(input bit mode, input int ckt, input logic [15:0] gxor, input bit spam,
                     input string tag);
    logic [15:0] msig;
    logic [4:0]  seen [$];
    bit          eff;
    bit          sig_nz;
    int          cycles;
    int          pcount;
    int          d0;
    int          bad;
    eff = mode && LfsrEn;
    ckt_sel = ckt;
    build_model(eff, ckt, msig);
    pcount = eff ? 31 : 32;
    @(negedge clk);
    start = 1'b1;
    lfsr_mode = mode;
    golden = msig ^ gxor;
    d0 = done_cnt;
    @(posedge clk); #1;
    check({tag, " busy_rise"}, busy, 1);
    check({tag, " cnt_clear"}, pat_cnt, 0);
    seen.delete();
    seen.push_back(dut_in);
    cycles = 0;
    sig_nz = 1'b0;
    while (done !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      start = spam ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      cycles++;
      if (signature != 16'h0) sig_nz = 1'b1;
      if (busy && dut_in != seen[$]) seen.push_back(dut_in);
    end
    check({tag, " run_len"}, cycles, 2 * pcount);
    check({tag, " done"}, done, 1);
    check({tag, " busy_fall"}, busy, 0);
    check({tag, " dut_in_idle"}, dut_in, 0);
    check({tag, " pat_cnt"}, pat_cnt, pcount);
    check({tag, " signature"}, signature, msig);
    check({tag, " pass"}, pass, (gxor == 16'h0));
    check({tag, " n_patterns"}, seen.size(), pcount);
    bad = 0;
    for (int i = 0; i < seen.size() && i < exp_pats.size(); i++)
      if (seen[i] != exp_pats[i]) bad++;
    check({tag, " pattern_seq"}, bad, 0);
    if (eff && seen.size() >= 3) begin
      check({tag, " lfsr_p0"}, seen[0], 5'h01);
      check({tag, " lfsr_p1"}, seen[1], 5'h14);
      check({tag, " lfsr_p2"}, seen[2], 5'h0A);
    end
    if (!eff && seen.size() == 32) check({tag, " last_pat"}, seen[31], 5'h1F);
    if (ckt == 1) check({tag, " sig_zero"}, sig_nz, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " done_pulse"}, done, 0);
    check({tag, " pass_hold"}, pass, (gxor == 16'h0));
    check({tag, " sig_hold"}, signature, msig);
    check({tag, " done_count"}, done_cnt - d0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " pass"}, pass, 0);
    check({tag, " sig"}, signature, 0);
    check({tag, " pat_cnt"}, pat_cnt, 0);
    check({tag, " dut_in"}, dut_in, 0);
  endtask

  initial begin
    int   cyc;
    logic [15:0] gx;
    rst_n = 1'b0;
    start = 1'b0;
    lfsr_mode = 1'b0;
    golden = 16'h0;
    for (int i = 0; i < 32; i++) rand_tt[i] = 2'($urandom);

    vecs[0] = '{mode: 1'b0, ckt: 0, gxor: 16'h0000, spam: 1'b0};
    vecs[1] = '{mode: 1'b0, ckt: 0, gxor: 16'h0001, spam: 1'b0};
    vecs[2] = '{mode: 1'b0, ckt: 1, gxor: 16'h0000, spam: 1'b0};
    vecs[3] = '{mode: 1'b1, ckt: 0, gxor: 16'h0000, spam: 1'b0};
    vecs[4] = '{mode: 1'b1, ckt: 2, gxor: 16'h0000, spam: 1'b0};
    vecs[5] = '{mode: 1'b0, ckt: 2, gxor: 16'h8000, spam: 1'b0};
    vecs[6] = '{mode: 1'b0, ckt: 0, gxor: 16'h0000, spam: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run(vecs[i].mode, vecs[i].ckt, vecs[i].gxor, vecs[i].spam, $sformatf("vec%0d", i));

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) rand_tt[i] = 2'($urandom);
      gx = ($urandom_range(0, 1) == 0) ? 16'h0 : (16'($urandom) | 16'h0100);
      run(1'($urandom), 2, gx, 1'($urandom), $sformatf("rnd%0d", r));
    end

    // Held start restarts after done; then a mid-run reset aborts the run.
    ckt_sel = 0;
    @(negedge clk);
    start = 1'b1;
    lfsr_mode = 1'b0;
    cyc = 0;
    @(posedge clk); #1;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("held done_seen", done, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("held restart", busy, 1);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (pat_cnt != 6'd10 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst reach_pat10", pat_cnt, 10);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 0, 16'h0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
